// File: rtl/fust_issue_sched.sv
// Scoreboard issue scheduler: NUM_FU rows with dependency tags, writeback wakeup,
// saturating age and oldest-ready single issue over a valid/ready slot.
module fust_issue_sched #(
  parameter int unsigned NUM_FU = 5,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned AGE_W  = 3,
  localparam int unsigned FU_W  = $clog2(NUM_FU),
  localparam int unsigned TAG_W = $clog2(NUM_FU + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic                    disp_valid,
  input  logic [FU_W-1:0]         disp_fu,
  input  logic [REG_W-1:0]        disp_rs1,
  input  logic [REG_W-1:0]        disp_rs2,
  input  logic [REG_W-1:0]        disp_rd,
  input  logic [TAG_W-1:0]        disp_t1,
  input  logic [TAG_W-1:0]        disp_t2,
  output logic [NUM_FU-1:0]       disp_ready,
  output logic                    disp_err,
  input  logic                    wb_valid,
  input  logic [FU_W-1:0]         wb_fu,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [FU_W-1:0]         iss_fu,
  output logic [REG_W-1:0]        iss_rs1,
  output logic [REG_W-1:0]        iss_rs2,
  output logic [REG_W-1:0]        iss_rd,
  output logic [2*NUM_FU-1:0]     fust_state,
  output logic [AGE_W*NUM_FU-1:0] fust_age
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RDY   = 2'd2,
    ST_EX    = 2'd3
  } row_state_e;

  localparam int unsigned CMP_W = TAG_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  // Compare one bit wider so wb_fu+1 never wraps onto a real tag.
  function automatic logic tag_wake(input logic [TAG_W-1:0] tag, input logic v,
                                    input logic [FU_W-1:0] fu);
    return v && (CMP_W'(tag) == (CMP_W'(fu) + CMP_W'(1)));
  endfunction

  row_state_e       r_state [NUM_FU];
  logic [REG_W-1:0] r_rs1   [NUM_FU];
  logic [REG_W-1:0] r_rs2   [NUM_FU];
  logic [REG_W-1:0] r_rd    [NUM_FU];
  logic [TAG_W-1:0] r_t1    [NUM_FU];
  logic [TAG_W-1:0] r_t2    [NUM_FU];
  logic [AGE_W-1:0] r_age   [NUM_FU];

  row_state_e       w_state_nxt [NUM_FU];
  logic [REG_W-1:0] w_rs1_nxt   [NUM_FU];
  logic [REG_W-1:0] w_rs2_nxt   [NUM_FU];
  logic [REG_W-1:0] w_rd_nxt    [NUM_FU];
  logic [TAG_W-1:0] w_t1_nxt    [NUM_FU];
  logic [TAG_W-1:0] w_t2_nxt    [NUM_FU];
  logic [AGE_W-1:0] w_age_nxt   [NUM_FU];
  logic [TAG_W-1:0] w_t1_eff    [NUM_FU];
  logic [TAG_W-1:0] w_t2_eff    [NUM_FU];

  logic [NUM_FU-1:0] w_elig;
  logic [NUM_FU-1:0] w_done;
  logic              w_found;
  logic [FU_W-1:0]   w_sel;
  logic [AGE_W-1:0]  w_best_age;
  logic [REG_W-1:0]  w_sel_rs1;
  logic [REG_W-1:0]  w_sel_rs2;
  logic [REG_W-1:0]  w_sel_rd;
  logic              w_disp_ok;
  logic              w_slot_free;
  logic              w_take;

  logic              r_iss_valid;
  logic [FU_W-1:0]   r_iss_fu;
  logic [REG_W-1:0]  r_iss_rs1;
  logic [REG_W-1:0]  r_iss_rs2;
  logic [REG_W-1:0]  r_iss_rd;
  logic              r_disp_err;

  assign w_slot_free = ~r_iss_valid | iss_ready;
  assign w_take      = w_slot_free & w_found;

  // Wakeup bypass, eligibility, dispatch readiness and oldest-first selection.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_best_age = '0;
    w_sel_rs1  = '0;
    w_sel_rs2  = '0;
    w_sel_rd   = '0;
    w_disp_ok  = 1'b0;
    w_elig     = '0;
    w_done     = '0;
    disp_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_t1_eff[i] = tag_wake(r_t1[i], wb_valid, wb_fu) ? '0 : r_t1[i];
      w_t2_eff[i] = tag_wake(r_t2[i], wb_valid, wb_fu) ? '0 : r_t2[i];
      w_elig[i]   = ((r_state[i] == ST_WAIT) || (r_state[i] == ST_RDY)) &&
                    (w_t1_eff[i] == '0) && (w_t2_eff[i] == '0);
      w_done[i]   = (r_state[i] == ST_EX) && wb_valid && (wb_fu == FU_W'(i));
      disp_ready[i] = (r_state[i] == ST_EMPTY) || w_done[i];
      if (disp_valid && (disp_fu == FU_W'(i)) && disp_ready[i]) begin
        w_disp_ok = 1'b1;
      end
      if (w_elig[i] && (!w_found || (r_age[i] > w_best_age))) begin
        w_found    = 1'b1;
        w_sel      = FU_W'(i);
        w_best_age = r_age[i];
        w_sel_rs1  = r_rs1[i];
        w_sel_rs2  = r_rs2[i];
        w_sel_rd   = r_rd[i];
      end
    end
  end

  // Per-row next state: dispatch > completion > issue > aging.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_state_nxt[i] = r_state[i];
      w_rs1_nxt[i]   = r_rs1[i];
      w_rs2_nxt[i]   = r_rs2[i];
      w_rd_nxt[i]    = r_rd[i];
      w_t1_nxt[i]    = w_t1_eff[i];
      w_t2_nxt[i]    = w_t2_eff[i];
      w_age_nxt[i]   = r_age[i];
      if (w_disp_ok && (disp_fu == FU_W'(i))) begin
        w_state_nxt[i] = ST_WAIT;
        w_rs1_nxt[i]   = disp_rs1;
        w_rs2_nxt[i]   = disp_rs2;
        w_rd_nxt[i]    = disp_rd;
        w_t1_nxt[i]    = tag_wake(disp_t1, wb_valid, wb_fu) ? '0 : disp_t1;
        w_t2_nxt[i]    = tag_wake(disp_t2, wb_valid, wb_fu) ? '0 : disp_t2;
        w_age_nxt[i]   = '0;
      end else if (w_done[i]) begin
        w_state_nxt[i] = ST_EMPTY;
        w_age_nxt[i]   = '0;
      end else if (w_take && (w_sel == FU_W'(i))) begin
        w_state_nxt[i] = ST_EX;
        w_age_nxt[i]   = '0;
      end else if ((r_state[i] == ST_WAIT) || (r_state[i] == ST_RDY)) begin
        if (w_elig[i]) begin
          w_state_nxt[i] = ST_RDY;
        end
        w_age_nxt[i] = (r_age[i] == AGE_MAX) ? AGE_MAX : r_age[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= ST_EMPTY;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_rd[i]    <= '0;
        r_t1[i]    <= '0;
        r_t2[i]    <= '0;
        r_age[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= ST_EMPTY;
        r_t1[i]    <= '0;
        r_t2[i]    <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_rs1[i]   <= w_rs1_nxt[i];
        r_rs2[i]   <= w_rs2_nxt[i];
        r_rd[i]    <= w_rd_nxt[i];
        r_t1[i]    <= w_t1_nxt[i];
        r_t2[i]    <= w_t2_nxt[i];
        r_age[i]   <= w_age_nxt[i];
      end
    end
  end

  // Issue slot: reloads only when free; payload holds while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iss_valid <= 1'b0;
      r_iss_fu    <= '0;
      r_iss_rs1   <= '0;
      r_iss_rs2   <= '0;
      r_iss_rd    <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_iss_valid <= w_found;
      if (w_found) begin
        r_iss_fu  <= w_sel;
        r_iss_rs1 <= w_sel_rs1;
        r_iss_rs2 <= w_sel_rs2;
        r_iss_rd  <= w_sel_rd;
      end
    end
  end

  // Sticky error; survives flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp_err <= 1'b0;
    end else if (disp_valid && !w_disp_ok) begin
      r_disp_err <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fust_state[2*i +: 2]      = r_state[i];
      fust_age[AGE_W*i +: AGE_W] = r_age[i];
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_fu    = r_iss_fu;
  assign iss_rs1   = r_iss_rs1;
  assign iss_rs2   = r_iss_rs2;
  assign iss_rd    = r_iss_rd;
  assign disp_err  = r_disp_err;

endmodule
